// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect from
// execute, and the decoded-instruction output register.
//
// Handshake rules:
//   imem: a request is live while imem_req=1; imem_ack in the same cycle
//         delivers imem_rdata for imem_addr. imem_ack is meaningless while
//         imem_req=0, and imem_addr is held until the ack arrives.
//   inst: strict valid/ready. inst_out/inst_pc/inst_pc4 are stable while
//         inst_valid=1 and inst_ready=0; a transfer happens on an edge
//         where both are 1.
// The misalign line exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_target,
        output inst_valid, inst_out, inst_pc, inst_pc4,
`ifdef FETCH_MISALIGN_TRAP_EN
        output misalign,
`endif
        input  inst_ready
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_target,
        input  inst_valid, inst_out, inst_pc, inst_pc4,
`ifdef FETCH_MISALIGN_TRAP_EN
        input  misalign,
`endif
        output inst_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: issues word fetches at the internal pc, captures the
// returned word into a one-entry output register and follows redirects.
// A redirect that arrives while a fetch is outstanding parks in DROP until
// the stale response returns, then resumes at the (last) redirect target.
// Optional: FETCH_MISALIGN_TRAP_EN adds a TRAP state and the misalign output
// for redirect targets that are not word aligned; without it the low two
// target bits are forced to zero.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    pc_fetch_if.master       bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_DROP = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd2
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        req_c;
    logic [31:0] tgt;
    logic [31:0] pc_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    logic tgt_bad;
    assign tgt     = bus.redirect_target;
    assign tgt_bad = |bus.redirect_target[1:0];
`else
    logic unused_tgt_lsb;
    assign tgt            = {bus.redirect_target[31:2], 2'b00};
    assign unused_tgt_lsb = ^bus.redirect_target[1:0];
`endif

    // Sequential next pc; 32-bit add wraps naturally at the top of memory.
    assign pc_next = pc + 32'd4;

    // Request whenever the output register can take a word, or while a
    // stale fetch must be drained; never during reset or trap.
    always_comb begin
        req_c = 1'b0;
        if (!reset) begin
            case (state)
                ST_REQ:  req_c = !inst_valid || bus.inst_ready;
                ST_DROP: req_c = 1'b1;
                default: req_c = 1'b0;
            endcase
        end
    end

    // Fetch FSM with the output register; redirect dominates ack and ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= NOP_INSTR;
            inst_pc    <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_REQ: begin
                    if (bus.redirect) begin
                        inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (tgt_bad) begin
                            state      <= ST_TRAP;
                            misalign_q <= 1'b1;
                        end else
`endif
                        if (req_c && !bus.imem_ack) begin
                            // Outstanding fetch: keep its address until it returns.
                            state   <= ST_DROP;
                            pend_pc <= tgt;
                        end else begin
                            pc <= tgt;
                        end
                    end else if (req_c && bus.imem_ack) begin
                        inst_out   <= bus.imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc_next;
                    end else if (inst_valid && bus.inst_ready) begin
                        inst_valid <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (bus.redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (tgt_bad) begin
                            state      <= ST_TRAP;
                            misalign_q <= 1'b1;
                        end else
`endif
                        if (bus.imem_ack) begin
                            pc    <= tgt;
                            state <= ST_REQ;
                        end else begin
                            pend_pc <= tgt;
                        end
                    end else if (bus.imem_ack) begin
                        pc    <= pend_pc;
                        state <= ST_REQ;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                ST_TRAP: begin
                    if (bus.redirect && !tgt_bad) begin
                        pc         <= tgt;
                        misalign_q <= 1'b0;
                        state      <= ST_REQ;
                    end
                end
`endif
                default: state <= ST_REQ;
            endcase
        end
    end

    assign bus.imem_req   = req_c;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_out   = inst_out;
    assign bus.inst_pc    = inst_pc;
    assign bus.inst_pc4   = inst_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign   = misalign_q;
`endif
    assign dbg_state      = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table for the main fetch flow,
// hand-written sequences for reset-in-DROP, target masking / trap, and the
// top-of-memory wrap on a second instance.
module tb_pc_fetch_unit;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_w;

    pc_fetch_if bus ();
    pc_fetch_if bus_w ();

    pc_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_w),
        .dbg_state (dbg_state_w)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] tgt;
        logic        rdy;
        logic        cap;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mkv(logic ack, logic [31:0] rdata, logic rd,
                                 logic [31:0] tgt, logic rdy, logic cap,
                                 logic e_req, logic [31:0] e_addr,
                                 logic e_valid, logic [31:0] e_pc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.rd = rd; v.tgt = tgt; v.rdy = rdy;
        v.cap = cap; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs at negedge, record an expected capture,
    // then let the scoreboard look for a transfer that will happen at the edge.
    task automatic drive(input logic ack, input logic [31:0] rdata, input logic rd,
                         input logic [31:0] tgt, input logic rdy, input logic cap,
                         input logic [31:0] cap_pc);
        logic [63:0] e;
        @(negedge clk);
        bus.imem_ack        = ack;
        bus.imem_rdata      = rdata;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        bus.inst_ready      = rdy;
        if (cap) exp_q.push_back({cap_pc, rdata});
        #1;
        if (bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_xfer", bus.inst_pc, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst_pc", bus.inst_pc, e[63:32]);
                chk("sb_inst_out", bus.inst_out, e[31:0]);
                chk("sb_inst_pc4", bus.inst_pc4, e[63:32] + 32'd4);
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        reset               = 1'b1;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.inst_ready      = 1'b1;
        bus_w.imem_ack        = 1'b0;
        bus_w.imem_rdata      = 32'h0;
        bus_w.redirect        = 1'b0;
        bus_w.redirect_target = 32'h0;
        bus_w.inst_ready      = 1'b1;

        //               ack rdata          rd tgt        rdy cap req addr           vld pc
        vecs[0]  = mkv(1, 32'hA000_0000, 0, 32'h0,   1, 1, 1, 32'h0000_0000, 0, 32'h0);
        vecs[1]  = mkv(1, 32'hA000_0001, 0, 32'h0,   1, 1, 1, 32'h0000_0004, 1, 32'h0);
        vecs[2]  = mkv(1, 32'hA000_0002, 0, 32'h0,   1, 1, 1, 32'h0000_0008, 1, 32'h4);
        vecs[3]  = mkv(0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0000_000C, 1, 32'h8);
        vecs[4]  = mkv(0, 32'h0,         0, 32'h0,   0, 0, 1, 32'h0000_000C, 0, 32'h0);
        vecs[5]  = mkv(1, 32'hB000_0000, 0, 32'h0,   0, 1, 1, 32'h0000_000C, 0, 32'h0);
        vecs[6]  = mkv(0, 32'h0,         0, 32'h0,   0, 0, 0, 32'h0000_0010, 1, 32'hC);
        vecs[7]  = mkv(1, 32'hDEAD_BEEF, 0, 32'h0,   0, 0, 0, 32'h0000_0010, 1, 32'hC);
        vecs[8]  = mkv(0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0000_0010, 1, 32'hC);
        vecs[9]  = mkv(1, 32'hBAD0_0001, 1, 32'h8,   1, 0, 1, 32'h0000_0010, 0, 32'h0);
        vecs[10] = mkv(0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0000_0008, 0, 32'h0);
        vecs[11] = mkv(0, 32'h0,         1, 32'h40,  1, 0, 1, 32'h0000_0008, 0, 32'h0);
        vecs[12] = mkv(0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0000_0008, 0, 32'h0);
        vecs[13] = mkv(1, 32'hBAD0_0002, 0, 32'h0,   1, 0, 1, 32'h0000_0008, 0, 32'h0);
        vecs[14] = mkv(1, 32'hC000_0000, 0, 32'h0,   1, 1, 1, 32'h0000_0040, 0, 32'h0);
        vecs[15] = mkv(0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0000_0044, 1, 32'h40);
        vecs[16] = mkv(0, 32'h0,         1, 32'h80,  1, 0, 1, 32'h0000_0044, 0, 32'h0);
        vecs[17] = mkv(0, 32'h0,         1, 32'h100, 1, 0, 1, 32'h0000_0044, 0, 32'h0);
        vecs[18] = mkv(1, 32'hBAD0_0003, 0, 32'h0,   1, 0, 1, 32'h0000_0044, 0, 32'h0);
        vecs[19] = mkv(1, 32'hD000_0000, 0, 32'h0,   1, 1, 1, 32'h0000_0100, 0, 32'h0);
        vecs[20] = mkv(0, 32'h0,         0, 32'h0,   0, 0, 0, 32'h0000_0104, 1, 32'h100);
        vecs[21] = mkv(0, 32'h0,         0, 32'h0,   1, 0, 1, 32'h0000_0104, 1, 32'h100);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        chk("rst_inst_out", bus.inst_out, 32'h0000_0013);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", {31'b0, bus.misalign}, 32'd0);
`endif
        reset = 1'b0;

        // Table: sequential fetch, stalls, redirect with ack, DROP, last-wins
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].rd, vecs[i].tgt,
                  vecs[i].rdy, vecs[i].cap, vecs[i].e_addr);
            chk($sformatf("v%0d_imem_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_inst_pc", i), bus.inst_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_inst_pc4", i), bus.inst_pc4, vecs[i].e_pc + 32'd4);
            end
        end

        // Reset asserted while a stale fetch is being drained
        drive(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        chk("drop_enter_req", {31'b0, bus.imem_req}, 32'd1);
        idle();
        chk("drop_state", {30'b0, dbg_state}, 32'd1);
        chk("drop_hold_addr", bus.imem_addr, 32'h104);
        chk("drop_req", {31'b0, bus.imem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstdrop_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rstdrop_valid", {31'b0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstdrop_state", {30'b0, dbg_state}, 32'd0);
        chk("rstdrop_resume_addr", bus.imem_addr, 32'h0);
        chk("rstdrop_resume_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rstdrop_valid2", {31'b0, bus.inst_valid}, 32'd0);
        drive(1'b1, 32'hE000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        idle();
        chk("rstdrop_first_valid", {31'b0, bus.inst_valid}, 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps, aligned redirect recovers
        drive(1'b0, 32'h0, 1'b1, 32'h102, 1'b1, 1'b0, 32'h0);
        idle();
        chk("trap_misalign", {31'b0, bus.misalign}, 32'd1);
        chk("trap_req", {31'b0, bus.imem_req}, 32'd0);
        chk("trap_state", {30'b0, dbg_state}, 32'd2);
        drive(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
        idle();
        chk("untrap_misalign", {31'b0, bus.misalign}, 32'd0);
        chk("untrap_req", {31'b0, bus.imem_req}, 32'd1);
        chk("untrap_addr", bus.imem_addr, 32'h100);
`else
        // Low target bits are dropped
        drive(1'b1, 32'hBAD0_0004, 1'b1, 32'h203, 1'b1, 1'b0, 32'h0);
        idle();
        chk("mask_addr", bus.imem_addr, 32'h200);
        chk("mask_valid", {31'b0, bus.inst_valid}, 32'd0);
`endif

        // Top-of-memory wrap on the second instance
        @(negedge clk);
        bus_w.imem_ack   = 1'b1;
        bus_w.imem_rdata = 32'hF000_0000;
        #1;
        chk("wrap_first_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_first_req", {31'b0, bus_w.imem_req}, 32'd1);
        @(negedge clk);
        bus_w.imem_ack = 1'b0;
        #1;
        chk("wrap_next_addr", bus_w.imem_addr, 32'h0000_0000);
        chk("wrap_valid", {31'b0, bus_w.inst_valid}, 32'd1);
        chk("wrap_inst_pc", bus_w.inst_pc, 32'hFFFF_FFFC);
        chk("wrap_inst_pc4", bus_w.inst_pc4, 32'h0000_0000);
        chk("wrap_inst_out", bus_w.inst_out, 32'hF000_0000);

        // Report
        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the value of inst_out while no instruction has been captured.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_ack  input  1  memory returns imem_rdata for the current request this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redirect  input  1  taken branch/jump from execute (the orJump condition).
REQ-010 redirect_target  input  32  new PC (PC+imm or jalr result).
REQ-011 inst_valid  output  1  inst_out/inst_pc/inst_pc4 hold a valid instruction.
REQ-012 inst_ready  input  1  downstream decode accepts the instruction this cycle.
REQ-013 inst_out  output  32  instruction word to decode.
REQ-014 inst_pc  output  32  address of inst_out.
REQ-015 inst_pc4  output  32  inst_pc+4, the sequential next-PC for execute.
REQ-016 misalign  output  1  misaligned-redirect trap; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-017 The FSM SHALL have states REQ (normal fetch), DROP (discard stale response) and TRAP (with macro only).
REQ-018 In REQ, imem_req SHALL be 1 when the output register is free: !inst_valid or inst_ready.
REQ-019 imem_addr SHALL equal the internal pc and SHALL stay stable while imem_req=1 and imem_ack=0.
REQ-020 imem_ack SHALL be ignored when imem_req=0.
REQ-021 On imem_ack in REQ with no redirect: inst_out<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, stay in REQ.
REQ-022 inst_valid=1 and inst_ready=1 with no new ack SHALL clear inst_valid; ack and ready together SHALL give back-to-back throughput of one instruction per cycle.
REQ-023 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-024 inst_pc4 SHALL be combinationally inst_pc+4 with the same wrap rule.
REQ-025 Redirect takes priority over ack and ready: inst_valid<=0 and pc<=redirect_target in the same edge.
REQ-026 Redirect while imem_req=1 and imem_ack=0 SHALL move to DROP, hold imem_req=1 with the old imem_addr until ack, discard that data, then return to REQ at the new pc.
REQ-027 Redirect arriving in DROP SHALL overwrite the pending target; the last redirect wins.
REQ-028 Redirect together with imem_ack SHALL discard the data and stay in REQ at redirect_target.
REQ-029 inst_valid SHALL stay 0 in DROP.

Reset
REQ-030 While reset=1 at an edge: pc<=RESET_PC, state<=REQ, inst_valid<=0, inst_out<=NOP_INSTR, inst_pc<=0, misalign<=0.
REQ-031 imem_req SHALL be 0 in any cycle where reset=1.
REQ-032 Reset during DROP or TRAP SHALL abandon the outstanding request with no data captured.

Configuration
REQ-033 With FETCH_MISALIGN_TRAP_EN defined, a redirect_target with [1:0]!=0 enters TRAP, sets misalign=1 and issues no fetch.
REQ-034 TRAP is left only by reset or by an aligned redirect, which clears misalign and resumes REQ.
REQ-035 Without FETCH_MISALIGN_TRAP_EN, redirect_target[1:0] is forced to 2'b00, there is no TRAP state, and the misalign port does not exist.

Verification
REQ-036 Reset, then ack every cycle with ready=1: inst_pc sequence is 0x0, 0x4, 0x8, with inst_pc4 0x4, 0x8, 0xC.
REQ-037 ready=0 with inst_valid=1: imem_req=0, and inst_out holds its value until ready rises.
REQ-038 Ack delayed 3 cycles at addr 0x8; redirect to 0x40 in cycle 1: addr 0x8 is held until ack, its data is dropped, the next request is 0x40, and no inst_valid is raised for 0x8.
REQ-039 RESET_PC=32'hFFFF_FFFC with one ack: the next imem_addr is 0x0000_0000.
REQ-040 With macro, redirect to 0x102: misalign=1 and imem_req=0; then redirect to 0x100: misalign=0 and imem_addr=0x100.
REQ-041 Reset asserted mid-DROP: the next cycle has imem_req=0 and inst_valid=0, then fetch resumes at RESET_PC.
